// File: rtl/sort4_controller.sv
// Sequential four-element ascending sorter: six bubble-sort compare/exchange
// steps through one shared unsigned comparator, reporting the exchange count.
module sort4_controller #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [4*W-1:0] din,
  output logic           busy,
  output logic           done,
  output logic [4*W-1:0] dout,
  output logic [2:0]     swaps
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SORT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state_reg;
  logic [2:0]          step_reg;
  logic [2:0]          cnt_reg;
  logic [2:0]          cnt_next;
  logic [3:0][W-1:0]   work_reg;
  logic [3:0][W-1:0]   work_next;
  logic [3:0][W-1:0]   din_elem;
  logic [4*W-1:0]      dout_reg;
  logic [2:0]          swaps_reg;

  logic [1:0]          idx;
  logic [1:0]          idx_hi;
  logic [W-1:0]        cmp_a;
  logic [W-1:0]        cmp_b;
  logic                gt;
  logic                load;
  logic                exch;

  assign din_elem = din;

  // Pair schedule: passes of 3, 2 and 1 compares.
  always_comb begin
    idx = 2'd0;
    case (step_reg)
      3'd0:    idx = 2'd0;
      3'd1:    idx = 2'd1;
      3'd2:    idx = 2'd2;
      3'd3:    idx = 2'd0;
      3'd4:    idx = 2'd1;
      3'd5:    idx = 2'd0;
      default: idx = 2'd0;
    endcase
  end

  assign idx_hi = idx + 2'd1;
  assign cmp_a  = work_reg[idx];
  assign cmp_b  = work_reg[idx_hi];
  assign gt     = cmp_a > cmp_b;

  assign load = (state_reg == IDLE) && start;
  assign exch = (state_reg == SORT) && gt;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_elem
      assign work_next[gi] = load                          ? din_elem[gi] :
                             (exch && (idx == 2'(gi)))    ? cmp_b :
                             (exch && (idx_hi == 2'(gi))) ? cmp_a :
                                                            work_reg[gi];
    end
  endgenerate

  assign cnt_next = load ? 3'd0 : (exch ? cnt_reg + 3'd1 : cnt_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      step_reg  <= 3'd0;
      cnt_reg   <= 3'd0;
      work_reg  <= '0;
      dout_reg  <= '0;
      swaps_reg <= 3'd0;
    end else begin
      work_reg <= work_next;
      cnt_reg  <= cnt_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SORT;
            step_reg  <= 3'd0;
          end
        end
        SORT: begin
          if (step_reg == 3'd5) begin
            // Publish the post-exchange values of the final step.
            state_reg <= DONE;
            step_reg  <= 3'd0;
            dout_reg  <= work_next;
            swaps_reg <= cnt_next;
          end else begin
            step_reg <= step_reg + 3'd1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy  = (state_reg == SORT);
  assign done  = (state_reg == DONE);
  assign dout  = dout_reg;
  assign swaps = swaps_reg;

endmodule

// File: tb/tb_sort4_controller.sv
// Randomized bench for sort4_controller against a rank-based sorting model.
module tb_sort4_controller;
  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [4*W-1:0] din;
  logic           busy;
  logic           done;
  logic [4*W-1:0] dout;
  logic [2:0]     swaps;

  int n_checks;
  int n_errors;
  logic [15:0] exp_dout;
  logic [2:0]  exp_swaps;

  sort4_controller #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .swaps (swaps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Sorted result by rank; exchange count is the number of inversions.
  function automatic void model(input logic [15:0] d, output logic [15:0] s, output logic [2:0] sw);
    int e[4];
    int rank;
    int inv;
    for (int i = 0; i < 4; i++) e[i] = int'(d[i*4 +: 4]);
    s = '0;
    inv = 0;
    for (int i = 0; i < 4; i++) begin
      rank = 0;
      for (int j = 0; j < 4; j++) begin
        if (e[j] < e[i] || (e[j] == e[i] && j < i)) rank++;
        if (j > i && e[i] > e[j]) inv++;
      end
      s[rank*4 +: 4] = 4'(e[i]);
    end
    sw = 3'(inv);
  endfunction

  task automatic do_sort(input logic [15:0] d, input bit inject);
    logic [15:0] m_dout;
    logic [2:0]  m_sw;
    int n;
    int busy_cnt;
    model(d, m_dout, m_sw);
    @(negedge clk);
    din   = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) busy_cnt++;
      check_eq("hold_dout", dout, exp_dout);
      check_eq("hold_swaps", swaps, exp_swaps);
      if (inject && (n == 1 || n == 5)) begin
        start = 1'b1;
        din   = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_eq("latency", n, 6);
    check_eq("busy_cycles", busy_cnt, 6);
    check_eq("busy_in_done", busy, 1'b0);
    check_eq("dout", dout, m_dout);
    check_eq("swaps", swaps, m_sw);
    exp_dout  = m_dout;
    exp_swaps = m_sw;
    @(negedge clk);
    check_eq("done_pulse", done, 1'b0);
    check_eq("idle_busy", busy, 1'b0);
    $display("sort din=%h dout=%h swaps=%0d inject=%0d", d, dout, swaps, inject);
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] m_dout;
    logic [2:0]  m_sw;
    int last_done;
    int n_done;
    int drain;
    n_checks  = 0;
    n_errors  = 0;
    exp_dout  = '0;
    exp_swaps = '0;
    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_dout", dout, 16'h0);
    check_eq("rst_swaps", swaps, 3'd0);
    rst_n = 1'b1;

    do_sort(16'h1234, 1'b0);
    check_eq("dir_1234", dout, 16'h4321);
    check_eq("dir_1234_sw", swaps, 3'd6);
    do_sort(16'h4321, 1'b0);
    check_eq("dir_4321_sw", swaps, 3'd0);
    do_sort(16'h7777, 1'b0);
    check_eq("dir_7777", dout, 16'h7777);
    do_sort(16'h20CA, 1'b1);
    check_eq("dir_20CA", dout, 16'hCA20);
    check_eq("dir_20CA_sw", swaps, 3'd4);
    do_sort(16'h9F15, 1'b0);

    // Continuous start: done pulses every 8 cycles with identical results.
    d = 16'hB3E1;
    model(d, m_dout, m_sw);
    @(negedge clk);
    din = d;
    start = 1'b1;
    last_done = -1;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (last_done >= 0) check_eq("held_gap", c - last_done, 8);
        check_eq("held_dout", dout, m_dout);
        check_eq("held_swaps", swaps, m_sw);
        last_done = c;
        n_done++;
        $display("held start: done at cycle %0d dout=%h", c, dout);
      end
    end
    start = 1'b0;
    check_eq("held_count", n_done, 5);
    drain = 0;
    while ((busy === 1'b1 || done === 1'b1) && drain < 12) begin
      @(negedge clk);
      drain++;
    end
    check_eq("held_drain", busy | done, 1'b0);
    exp_dout  = m_dout;
    exp_swaps = m_sw;

    // Reset during the third busy cycle aborts the sort.
    @(negedge clk);
    din = 16'h5A3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_dout", dout, 16'h0);
    check_eq("abort_swaps", swaps, 3'd0);
    $display("reset mid-sort: busy=%0d dout=%h", busy, dout);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check_eq("abort_no_done", n_done, 0);
    exp_dout  = '0;
    exp_swaps = '0;
    do_sort(16'h5A3C, 1'b0);

    for (int t = 0; t < 40; t++) begin
      do_sort(16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
